// File: rtl/demultiplexer_2bit_buffered.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demultiplexer_2bit_buffered: routes one stream into two DEPTH-entry FIFOs |
// | Optional per-channel pop counters when DEMUX_COUNT_EN is defined.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module demultiplexer_2bit_buffered #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [7:0]       a_count,
  output logic [7:0]       b_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  logic [1:0]       full;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       valid;
  logic [1:0]       ready;
  logic [WIDTH-1:0] head [2];

  assign ready    = {b_ready, a_ready};
  // Acceptance looks only at the selected FIFO's registered occupancy.
  assign in_ready = !full[in_sel];

  generate
    for (genvar c = 0; c < 2; c++) begin : g_chan
      logic [WIDTH-1:0] mem [DEPTH];
      logic [AW-1:0]    wptr;
      logic [AW-1:0]    rptr;
      logic [AW:0]      occ;

      assign full[c]  = (occ == OCC_FULL);
      assign valid[c] = (occ != '0);
      assign push[c]  = in_valid && !full[in_sel] && (in_sel == 1'(c));
      assign pop[c]   = valid[c] && ready[c];
      assign head[c]  = mem[rptr];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
          wptr <= '0;
          rptr <= '0;
          occ  <= '0;
        end else begin
          if (push[c]) begin
            mem[wptr] <= in_data;
            wptr      <= wptr + AW'(1);
          end
          if (pop[c]) rptr <= rptr + AW'(1);
          case ({push[c], pop[c]})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: occ <= occ;
          endcase
        end
      end
    end
  endgenerate

  assign a_data  = head[0];
  assign b_data  = head[1];
  assign a_valid = valid[0];
  assign b_valid = valid[1];

`ifdef DEMUX_COUNT_EN
  logic [7:0] a_cnt;
  logic [7:0] b_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt <= 8'd0;
      b_cnt <= 8'd0;
    end else begin
      if (pop[0]) a_cnt <= a_cnt + 8'd1;
      if (pop[1]) b_cnt <= b_cnt + 8'd1;
    end
  end

  assign a_count = a_cnt;
  assign b_count = b_cnt;
`else
  assign a_count = 8'd0;
  assign b_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demultiplexer_2bit_buffered.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_demultiplexer_2bit_buffered: queue-model bench for the buffered demux |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_demultiplexer_2bit_buffered;
  localparam int WIDTH = 2;
  localparam int DEPTH = 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [7:0]       a_count;
  logic [7:0]       b_count;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  int               cnt_a = 0;
  int               cnt_b = 0;

  demultiplexer_2bit_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef DEMUX_COUNT_EN
    return 8'(n % 256);
`else
    return 8'(n - n);
`endif
  endfunction

  // One clock cycle: check outputs at the falling edge, then advance the model.
  task automatic cycle();
    bit rdy, pa, pb, acc;
    @(negedge clk);
    rdy = (in_sel ? qb.size() : qa.size()) < DEPTH;
    chk("in_ready", {7'd0, in_ready}, {7'd0, rdy});
    chk("a_valid", {7'd0, a_valid}, {7'd0, qa.size() != 0});
    chk("b_valid", {7'd0, b_valid}, {7'd0, qb.size() != 0});
    if (qa.size() != 0) chk("a_data", {6'd0, a_data}, {6'd0, qa[0]});
    if (qb.size() != 0) chk("b_data", {6'd0, b_data}, {6'd0, qb[0]});
    chk("a_count", a_count, exp_cnt(cnt_a));
    chk("b_count", b_count, exp_cnt(cnt_b));
    pa  = (qa.size() != 0) && a_ready;
    pb  = (qb.size() != 0) && b_ready;
    acc = in_valid && rdy;
    @(posedge clk);
    if (pa) begin void'(qa.pop_front()); cnt_a++; end
    if (pb) begin void'(qb.pop_front()); cnt_b++; end
    if (acc) begin
      if (in_sel) qb.push_back(in_data);
      else        qa.push_back(in_data);
    end
    #1;
  endtask

  task automatic drive(input bit v, input bit s, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    a_ready = 1'b0; b_ready = 1'b0;

    // Reset without any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_valid", {7'd0, a_valid}, 8'd0);
    chk("rst_b_valid", {7'd0, b_valid}, 8'd0);
    chk("rst_a_data", {6'd0, a_data}, 8'd0);
    chk("rst_b_data", {6'd0, b_data}, 8'd0);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_a_count", a_count, 8'd0);
    chk("rst_b_count", b_count, 8'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Consecutive pushes with both consumers ready
    a_ready = 1'b1; b_ready = 1'b1;
    drive(1, 0, 2'b01); cycle();
    drive(1, 1, 2'b10); cycle();
    drive(1, 0, 2'b11); cycle();
    drive(0, 0, 2'b00);
    repeat (3) cycle();

    // Fill A, then redirect to B
    a_ready = 1'b0;
    drive(1, 0, 2'b01); cycle();
    drive(1, 0, 2'b10); cycle();
    drive(1, 0, 2'b11); cycle();
    chk("t3_full_a", {7'd0, in_ready}, 8'd0);
    drive(1, 1, 2'b11); #1;
    chk("t3_b_open", {7'd0, in_ready}, 8'd1);
    cycle();

    // Full A with a pop: the push waits one cycle
    b_ready = 1'b1; a_ready = 1'b1;
    drive(1, 0, 2'b11); #1;
    chk("t4_blocked", {7'd0, in_ready}, 8'd0);
    cycle();
    chk("t4_reopen", {7'd0, in_ready}, 8'd1);
    a_ready = 1'b0;
    cycle();
    drive(0, 0, 2'b00);
    a_ready = 1'b1;
    repeat (3) cycle();

    // Asynchronous reset with A holding two words
    a_ready = 1'b0;
    drive(1, 0, 2'b10); cycle();
    drive(1, 0, 2'b01); cycle();
    drive(0, 0, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_a_valid", {7'd0, a_valid}, 8'd0);
    chk("t5_in_ready", {7'd0, in_ready}, 8'd1);
    qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
    #1 rst_n = 1'b1;
    cycle();

    // 256+ pops on A exercise the counter wrap
    a_ready = 1'b1; b_ready = 1'b0;
    for (int i = 0; i < 262; i++) begin
      drive(1, 0, WIDTH'(i));
      cycle();
    end
    drive(0, 0, 2'b00);
    repeat (3) cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 3)));
      a_ready = 1'($urandom_range(0, 1));
      b_ready = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
